// File: rtl/counter_ctrl_if.sv
// Board-side and counter-side signals of the counter front-end controller.
// The master is the controller; the slave is the board/counter environment.
interface counter_ctrl_if #(
  parameter int DATA_W = 4
);
  logic [3:0]        iKey_n;
  logic [DATA_W-1:0] iSw;
  logic [DATA_W-1:0] iCount;
  logic              oEnable;
  logic              oUp_down;
  logic              oClear;
  logic [DATA_W-1:0] oInitialValue;
  logic              oAuto;
  logic              oTerminal;

  modport master (
    input  iKey_n, iSw, iCount,
    output oEnable, oUp_down, oClear, oInitialValue, oAuto, oTerminal
  );

  modport slave (
    output iKey_n, iSw, iCount,
    input  oEnable, oUp_down, oClear, oInitialValue, oAuto, oTerminal
  );
endinterface

// File: rtl/counter_ctrl.sv
// Pushbutton front end for a 4-bit up/down counter: key sync/debounce, press
// decode, manual/auto FSM with periodic tick, load strobe and terminal flag.
module counter_ctrl #(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic           iClk,
  input  logic           iReset_n,
  counter_ctrl_if.master bus
);

  localparam int NKEY = 4;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TK_W = $clog2(TICK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  logic [NKEY-1:0]   r_sync_p0;
  logic [NKEY-1:0]   r_sync_p1;
  logic [1:0]        r_vld;
  logic [NKEY-1:0]   r_armed;
  logic [NKEY-1:0]   r_db_p2;
  logic [NKEY-1:0]   r_db_p3;
  logic [DB_W-1:0]   r_dbcnt [NKEY];
  logic [NKEY-1:0]   w_press;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TK_W-1:0]   r_tick;
  logic [TK_W-1:0]   w_tick_nxt;
  logic              r_enable;
  logic              r_clear;
  logic              r_up;
  logic [DATA_W-1:0] r_init;
  logic              r_auto;
  logic              r_term;
  logic              w_en_nxt;
  logic              w_clr_nxt;
  logic              w_up_nxt;
  logic [DATA_W-1:0] w_init_nxt;
  logic              w_load;
  logic              w_mode;
  logic              w_dir;
  logic              w_step;
  logic              w_wrap;

  function automatic logic is_terminal(input logic [DATA_W-1:0] cnt, input logic up);
    return up ? (&cnt) : ~(|cnt);
  endfunction

  // Stage p0/p1: two-flop synchronizer; r_vld marks when p1 holds a real sample
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_sync_p0 <= '1;
      r_sync_p1 <= '1;
      r_vld     <= '0;
    end else begin
      r_sync_p0 <= bus.iKey_n;
      r_sync_p1 <= r_sync_p0;
      r_vld     <= {r_vld[0], 1'b1};
    end
  end

  // Stage p2/p3: debounced level and its delayed copy for edge detection.
  // A key becomes armed only after it is seen released, so a key held
  // through reset cannot fire until it is released and pressed again.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_db_p2 <= '1;
      r_db_p3 <= '1;
      r_armed <= '0;
      for (int k = 0; k < NKEY; k++) r_dbcnt[k] <= '0;
    end else begin
      r_db_p3 <= r_db_p2;
      for (int k = 0; k < NKEY; k++) begin
        if (r_vld[1] && r_sync_p1[k]) r_armed[k] <= 1'b1;
        if (r_sync_p1[k] == r_db_p2[k]) begin
          r_dbcnt[k] <= '0;
        end else if (r_dbcnt[k] == DB_LAST) begin
          r_db_p2[k] <= r_sync_p1[k];
          r_dbcnt[k] <= '0;
        end else begin
          r_dbcnt[k] <= r_dbcnt[k] + DB_W'(1);
        end
      end
    end
  end

  assign w_press = r_armed & r_db_p3 & ~r_db_p2;

  // Event decode: load > mode > direction > step/tick
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = '0;
    w_en_nxt    = 1'b0;
    w_clr_nxt   = 1'b0;
    w_up_nxt    = r_up;
    w_init_nxt  = r_init;
    w_load      = w_press[2];
    w_mode      = w_press[3] & ~w_press[2];
    w_dir       = w_press[1];
    w_step      = w_press[0];
    w_wrap      = (r_tick == TK_LAST);

    if (w_dir) w_up_nxt = ~r_up;

    if (w_load) begin
      w_clr_nxt  = 1'b1;
      w_init_nxt = bus.iSw;
    end else if (w_mode) begin
      w_state_nxt = (r_state == S_MANUAL) ? S_AUTO : S_MANUAL;
    end else if (r_state == S_MANUAL) begin
      w_en_nxt = w_step;
    end else begin
      w_en_nxt   = w_wrap;
      w_tick_nxt = w_wrap ? '0 : r_tick + TK_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= S_MANUAL;
      r_tick   <= '0;
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
      r_up     <= 1'b1;
      r_init   <= '0;
      r_auto   <= 1'b0;
      r_term   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_enable <= w_en_nxt;
      r_clear  <= w_clr_nxt;
      r_up     <= w_up_nxt;
      r_init   <= w_init_nxt;
      r_auto   <= (w_state_nxt == S_AUTO);
      r_term   <= is_terminal(bus.iCount, r_up);
    end
  end

  assign bus.oEnable       = r_enable;
  assign bus.oUp_down      = r_up;
  assign bus.oClear        = r_clear;
  assign bus.oInitialValue = r_init;
  assign bus.oAuto         = r_auto;
  assign bus.oTerminal     = r_term;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Key press to output latency is 7 clock edges (2 sync + 4 debounce + 1 output).
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   en_cnt = 0;
  int   clr_cnt = 0;
  int   overlap = 0;
  int   dbl_en = 0;
  logic prev_en = 1'b0;
  int   c0;

  always #5 clk = ~clk;

  counter_ctrl_if #(.DATA_W(4)) bus ();

  counter_ctrl #(
    .DATA_W(4),
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(8)
  ) dut (
    .iClk(clk),
    .iReset_n(rst_n),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.oEnable === 1'b1) en_cnt++;
    if (bus.oClear === 1'b1) clr_cnt++;
    if (bus.oEnable === 1'b1 && bus.oClear === 1'b1) overlap++;
    if (prev_en === 1'b1 && bus.oEnable === 1'b1) dbl_en++;
    prev_en = bus.oEnable;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b1;
    bus.iKey_n  = 4'hF;
    bus.iSw     = 4'h0;
    bus.iCount  = 4'h0;

    // Reset asserted mid-cycle: outputs go to reset values at once
    #12;
    rst_n = 1'b0;
    #1;
    check("rst_enable", bus.oEnable, 1'b0);
    check("rst_clear", bus.oClear, 1'b0);
    check("rst_updown", bus.oUp_down, 1'b1);
    check("rst_init", bus.oInitialValue, 4'h0);
    check("rst_auto", bus.oAuto, 1'b0);
    check("rst_term", bus.oTerminal, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(5);

    // Bounce rejection on key0
    en_cnt = 0;
    bus.iKey_n[0] = 1'b0;
    step(2);
    bus.iKey_n[0] = 1'b1;
    step(1);
    bus.iKey_n[0] = 1'b0;
    step(6);
    check("bounce_no_early_en", bus.oEnable, 1'b0);
    check("bounce_early_count", en_cnt, 0);
    step(1);
    check("bounce_en_latency", bus.oEnable, 1'b1);
    step(1);
    check("bounce_en_one_cycle", bus.oEnable, 1'b0);
    step(2);
    bus.iKey_n[0] = 1'b1;
    step(10);
    check("bounce_single_pulse", en_cnt, 1);

    // Load
    bus.iSw = 4'hA;
    bus.iKey_n[2] = 1'b0;
    step(6);
    check("load_clear_early", bus.oClear, 1'b0);
    step(1);
    check("load_clear", bus.oClear, 1'b1);
    check("load_value", bus.oInitialValue, 4'hA);
    check("load_no_enable", bus.oEnable, 1'b0);
    step(1);
    check("load_clear_one_cycle", bus.oClear, 1'b0);
    bus.iKey_n[2] = 1'b1;
    step(10);
    bus.iSw = 4'h5;
    step(2);
    check("load_value_held", bus.oInitialValue, 4'hA);
    check("load_clear_count", clr_cnt, 1);

    // Auto mode entry and periodic ticks
    bus.iKey_n[3] = 1'b0;
    step(7);
    check("auto_entered", bus.oAuto, 1'b1);
    bus.iKey_n[3] = 1'b1;
    step(7);
    check("auto_no_early_tick", bus.oEnable, 1'b0);
    step(1);
    check("auto_first_tick", bus.oEnable, 1'b1);
    step(1);
    check("auto_tick_one_cycle", bus.oEnable, 1'b0);
    step(7);
    check("auto_second_tick", bus.oEnable, 1'b1);
    step(1);
    c0 = en_cnt;
    bus.iKey_n[0] = 1'b0;
    step(10);
    bus.iKey_n[0] = 1'b1;
    step(13);
    check("auto_step_ignored", en_cnt - c0, 2);
    check("auto_tick_phase", bus.oEnable, 1'b1);
    bus.iKey_n[3] = 1'b0;
    step(7);
    check("auto_exit", bus.oAuto, 1'b0);
    c0 = en_cnt;
    bus.iKey_n[3] = 1'b1;
    step(20);
    check("manual_no_ticks", en_cnt, c0);

    // Direction toggle and terminal count
    bus.iCount = 4'hF;
    step(2);
    check("term_up_ff", bus.oTerminal, 1'b1);
    bus.iKey_n[1] = 1'b0;
    step(7);
    check("dir_toggled", bus.oUp_down, 1'b0);
    step(1);
    check("term_down_ff", bus.oTerminal, 1'b0);
    bus.iKey_n[1] = 1'b1;
    step(10);
    bus.iCount = 4'h0;
    step(2);
    check("term_down_zero", bus.oTerminal, 1'b1);

    // Load and direction coincident with an auto tick
    bus.iKey_n[3] = 1'b0;
    step(7);
    check("prio_auto_entered", bus.oAuto, 1'b1);
    bus.iKey_n[3] = 1'b1;
    step(8);
    check("prio_first_tick", bus.oEnable, 1'b1);
    step(1);
    bus.iKey_n[2] = 1'b0;
    bus.iKey_n[1] = 1'b0;
    bus.iSw = 4'h3;
    step(7);
    check("prio_clear", bus.oClear, 1'b1);
    check("prio_enable_suppressed", bus.oEnable, 1'b0);
    check("prio_dir_applied", bus.oUp_down, 1'b1);
    check("prio_load_value", bus.oInitialValue, 4'h3);
    check("prio_state_kept", bus.oAuto, 1'b1);
    c0 = en_cnt;
    step(1);
    bus.iKey_n[2] = 1'b1;
    bus.iKey_n[1] = 1'b1;
    step(6);
    check("prio_no_tick_yet", en_cnt, c0);
    step(1);
    check("prio_tick_restarted", bus.oEnable, 1'b1);

    // Key held through reset must not fire until re-pressed
    bus.iKey_n[0] = 1'b0;
    step(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst2_auto", bus.oAuto, 1'b0);
    step(2);
    rst_n = 1'b1;
    c0 = en_cnt;
    step(20);
    check("held_key_no_event", en_cnt, c0);
    bus.iKey_n[0] = 1'b1;
    step(10);
    bus.iKey_n[0] = 1'b0;
    step(7);
    check("repress_enable", bus.oEnable, 1'b1);
    step(1);
    bus.iKey_n[0] = 1'b1;
    step(10);
    check("repress_single", en_cnt, c0 + 1);

    check("never_enable_and_clear", overlap, 0);
    check("never_double_enable", dbl_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Front-end controller that drives the control inputs of a 4-bit up/down counter from board pushbuttons and switches. It synchronizes and debounces four active-low keys and converts presses into single-cycle step, direction-toggle, load and mode-toggle events. It also generates periodic auto-count enables and flags terminal count from the counter's fed-back value. It sits between the board I/O and the counter.

Parameters:
DATA_W, 4, width of counter value, switch input and initial-value output
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key change (20 ms at 50 MHz)
TICK_CYCLES, 50000000, clock cycles between auto-mode enable pulses (1 Hz at 50 MHz)

Ports:
iClk  input  1  system clock; all logic on rising edge
iReset_n  input  1  asynchronous active-low reset
iKey_n  input  4  raw active-low pushbuttons: [0] step, [1] direction toggle, [2] load, [3] auto/manual toggle
iSw  input  DATA_W  switch value to load into the counter
iCount  input  DATA_W  counter's current output value (feedback)
oEnable  output  1  one-cycle count enable to counter
oUp_down  output  1  count direction, 1 = up
oClear  output  1  one-cycle load strobe to counter
oInitialValue  output  DATA_W  value to load, registered copy of iSw
oAuto  output  1  1 = auto-count mode active
oTerminal  output  1  counter at end of range in current direction

Behaviour:
- Reset (async, iReset_n low): oEnable=0, oClear=0, oUp_down=1, oInitialValue=0, oAuto=0, oTerminal=0; synchronizers, debounced states forced to released (1), debounce and tick counters 0, FSM in S_MANUAL. Reset mid-press: a key held through reset deassertion produces no event until it is released and pressed again.
- Input path per key: 2-flop synchronizer, then debouncer. The debounced state changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Press event: debounced state 1->0 transition; one-cycle internal pulse. Release generates nothing.
- All outputs registered: an event decoded in cycle N appears on outputs in cycle N+1.
- FSM states: S_MANUAL, S_AUTO.
  - S_MANUAL: step press -> oEnable=1 for one cycle.
  - S_MANUAL: mode press -> S_AUTO; oAuto=1; tick counter cleared.
  - S_AUTO: step presses ignored. Tick counter counts 0..TICK_CYCLES-1. On the wrap cycle oEnable=1 for one cycle, so the first enable comes TICK_CYCLES cycles after entry.
  - S_AUTO: mode press -> S_MANUAL; oAuto=0; pending tick discarded.
- Direction press (either state): oUp_down inverts.
- Load press (either state):
  - oInitialValue<=iSw and oClear=1 for one cycle; oEnable forced 0 in that cycle.
  - Tick counter cleared; FSM state unchanged.
- Simultaneous events in one cycle, priority load > mode toggle > direction toggle > step/tick.
  - Load suppresses step/tick and mode toggle; a direction toggle in the same cycle still applies.
  - Mode toggle suppresses step/tick.
  - A direction toggle coincident with step/tick applies both; the enable pulse sees the new oUp_down.
- oTerminal (registered from iCount and oUp_down): 1 when oUp_down=1 and iCount=all ones, or oUp_down=0 and iCount=0. The counter wraps naturally; oTerminal is informational and never blocks enables.
- oEnable and oClear are never high together, and are never high on two consecutive cycles from a single press.

Test Plan:
Use DEBOUNCE_CYCLES=4 and TICK_CYCLES=8 for all scenarios.
1. Reset state: assert iReset_n=0 mid-cycle -> all outputs at reset values immediately, oUp_down=1, oAuto=0.
2. Bounce rejection: toggle iKey_n[0] low for 2 cycles, high for 1 cycle, then low and hold 10 cycles -> exactly one oEnable pulse. It occurs 2 sync + 4 debounce + 1 output cycles after the final low edge. Releasing the key gives no pulse.
3. Load: iSw=4'hA, press key2 -> oClear=1 for one cycle, oInitialValue=4'hA, oEnable=0 that cycle. Changing iSw later leaves oInitialValue at 4'hA.
4. Auto mode: press key3 -> oAuto=1, oEnable pulses every 8 cycles with the first 8 cycles after entry. Press key0 during auto -> no extra pulse. Press key3 again -> pulses stop, oAuto=0.
5. Direction and terminal: iCount=4'hF, oUp_down=1 -> oTerminal=1. Press key1 -> oUp_down=0 and oTerminal=0 next cycle. Drive iCount=0 -> oTerminal=1.
6. Priority: make key2 and key1 events coincide in auto mode on a tick cycle -> oClear=1, oEnable=0, oUp_down toggled. The next tick comes 8 cycles later.
